// File: rtl/pifo_pkg.sv
// Shared pop-result types and constants for the vPIFO egress and TaskDistribute logic.
// These widths are fixed here. The lane count, buffer depth and counter width stay per-instance.
package pifo_pkg;

  localparam int unsigned PTW           = 16;
  localparam int unsigned MTW           = 0;
  localparam int unsigned DW            = MTW + PTW;
  localparam int unsigned TREE_NUM      = 4;
  localparam int unsigned TREE_NUM_BITS = (TREE_NUM > 1) ? $clog2(TREE_NUM) : 1;

  // A PIFO reports "nothing to pop" by returning an all-ones payload.
  localparam logic [PTW-1:0] EMPTY_DATA = '1;

  typedef struct packed {
    logic [TREE_NUM_BITS-1:0] tree_id;
    logic [DW-1:0]            data;
  } pop_result_t;

  function automatic logic is_empty_marker(input logic [DW-1:0] d);
    return d[PTW-1:0] == EMPTY_DATA;
  endfunction

endpackage

// File: rtl/pop_result_fifo.sv
// Per-lane synchronous FIFO of pop results. A push is accepted while the FIFO is full
// if a pop occurs in the same cycle. The head is read straight from registered storage.
module pop_result_fifo
  import pifo_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  pop_result_t wdata,
  input  logic        pop,
  output pop_result_t head,
  output logic        full,
  output logic        empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  pop_result_t   mem_q [DEPTH];
  pop_result_t   mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          wr_en, rd_en;

  assign full  = (count_q == FULL_CNT);
  assign empty = (count_q == '0);
  assign head  = mem_q[rd_ptr_q];
  assign rd_en = pop && !empty;
  assign wr_en = push && (!full || rd_en);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_en) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (rd_en) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({wr_en, rd_en})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/pifo_pop_collector.sv
// Collects level-0 pop results from every RPU lane and merges them round-robin into one egress stream.
// Build option POP_EMPTY_FILTER_EN: all-ones payloads (PIFO empty markers) are not captured.
module pifo_pop_collector
  import pifo_pkg::*;
#(
  parameter int unsigned LEVEL     = 4,
  parameter int unsigned RES_DEPTH = 4,
  parameter int unsigned CNT_W     = 8
) (
  input  logic                           i_clk,
  input  logic                           i_arst,
  input  logic [LEVEL-1:0]               i_pop_valid,
  input  logic [LEVEL*TREE_NUM_BITS-1:0] i_tree_id,
  input  logic [LEVEL*DW-1:0]            i_pop_data,
  output logic                           o_valid,
  input  logic                           i_ready,
  output logic [TREE_NUM_BITS-1:0]       o_tree_id,
  output logic [DW-1:0]                  o_data,
  output logic [$clog2(LEVEL)-1:0]       o_lane,
  output logic [LEVEL-1:0]               o_lane_full,
  output logic [CNT_W-1:0]               o_drop_cnt,
  output logic                           o_drop_err
);

  localparam int unsigned LW = $clog2(LEVEL);
  localparam int unsigned SW = CNT_W + LW + 1;

  typedef enum logic {ARB_FREE, ARB_HOLD} arb_state_e;

  pop_result_t      head [LEVEL];
  logic [LEVEL-1:0] full, empty, push, pop, drop;

  for (genvar k = 0; k < LEVEL; k++) begin : g_lane
    pop_result_t wr;
    logic        keep;

    assign wr.tree_id = i_tree_id[k*TREE_NUM_BITS +: TREE_NUM_BITS];
    assign wr.data    = i_pop_data[k*DW +: DW];
`ifdef POP_EMPTY_FILTER_EN
    assign keep = !is_empty_marker(wr.data);
`else
    assign keep = 1'b1;
`endif
    assign push[k] = i_pop_valid[k] && keep;
    assign drop[k] = push[k] && full[k] && !pop[k];

    pop_result_fifo #(.DEPTH(RES_DEPTH)) u_fifo (
      .clk   (i_clk),
      .rst   (i_arst),
      .push  (push[k]),
      .wdata (wr),
      .pop   (pop[k]),
      .head  (head[k]),
      .full  (full[k]),
      .empty (empty[k])
    );
  end

  arb_state_e     state_q, state_d;
  logic [LW-1:0]  rr_ptr_q, rr_ptr_d;
  logic [LW-1:0]  grant_q, grant_d;
  logic [LW-1:0]  grant, idx;
  logic           found, valid, hs;
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
  logic           drop_err_q, drop_err_d;
  logic [LW:0]    n_drop;
  logic [SW-1:0]  drop_sum;

  // A stalled grant is replayed from grant_q so a newly filled lane ahead of it cannot steal the slot.
  always_comb begin
    found = 1'b0;
    grant = rr_ptr_q;
    idx   = '0;
    for (int unsigned i = 0; i < LEVEL; i++) begin
      idx = rr_ptr_q + LW'(i);
      if (!found && !empty[idx]) begin
        found = 1'b1;
        grant = idx;
      end
    end
    if (state_q == ARB_HOLD) begin
      grant = grant_q;
    end
  end

  assign valid = !(&empty);
  assign hs    = valid && i_ready;
  assign pop   = {{(LEVEL-1){1'b0}}, hs} << grant;

  always_comb begin
    state_d  = ARB_FREE;
    grant_d  = grant_q;
    rr_ptr_d = rr_ptr_q;
    if (valid && !i_ready) begin
      state_d = ARB_HOLD;
      grant_d = grant;
    end
    if (hs) begin
      rr_ptr_d = grant + 1'b1;
    end
  end

  always_comb begin
    n_drop = '0;
    for (int unsigned k = 0; k < LEVEL; k++) begin
      n_drop = n_drop + (LW+1)'(drop[k]);
    end
    drop_sum   = SW'(drop_cnt_q) + SW'(n_drop);
    drop_cnt_d = (drop_sum > SW'({CNT_W{1'b1}})) ? '1 : drop_sum[CNT_W-1:0];
    drop_err_d = drop_err_q | (|drop);
  end

  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      state_q    <= ARB_FREE;
      rr_ptr_q   <= '0;
      grant_q    <= '0;
      drop_cnt_q <= '0;
      drop_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      grant_q    <= grant_d;
      drop_cnt_q <= drop_cnt_d;
      drop_err_q <= drop_err_d;
    end
  end

  assign o_valid     = valid;
  assign o_tree_id   = valid ? head[grant].tree_id : '0;
  assign o_data      = valid ? head[grant].data : '0;
  assign o_lane      = valid ? grant : '0;
  assign o_lane_full = full;
  assign o_drop_cnt  = drop_cnt_q;
  assign o_drop_err  = drop_err_q;

endmodule

// File: tb/tb_pifo_pop_collector.sv
// Directed bench for pifo_pop_collector (LEVEL=4, RES_DEPTH=4, PTW=16, CNT_W=8).
// Define POP_EMPTY_FILTER_EN for both the bench and the RTL when the filter is built in.
module tb_pifo_pop_collector;
  import pifo_pkg::*;

  localparam int unsigned LEVEL = 4;

  logic                           clk;
  logic                           arst;
  logic [LEVEL-1:0]               pop_valid;
  logic [LEVEL*TREE_NUM_BITS-1:0] tree_id;
  logic [LEVEL*DW-1:0]            pop_data;
  logic                           ready;
  logic                           o_valid;
  logic [TREE_NUM_BITS-1:0]       o_tree_id;
  logic [DW-1:0]                  o_data;
  logic [1:0]                     o_lane;
  logic [LEVEL-1:0]               o_lane_full;
  logic [7:0]                     o_drop_cnt;
  logic                           o_drop_err;

  int tests_run = 0;
  int tests_failed = 0;

  pifo_pop_collector #(.LEVEL(LEVEL), .RES_DEPTH(4), .CNT_W(8)) dut (
    .i_clk       (clk),
    .i_arst      (arst),
    .i_pop_valid (pop_valid),
    .i_tree_id   (tree_id),
    .i_pop_data  (pop_data),
    .o_valid     (o_valid),
    .i_ready     (ready),
    .o_tree_id   (o_tree_id),
    .o_data      (o_data),
    .o_lane      (o_lane),
    .o_lane_full (o_lane_full),
    .o_drop_cnt  (o_drop_cnt),
    .o_drop_err  (o_drop_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Advance one rising edge and settle 1 time unit past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    pop_valid = '0;
    tree_id   = '0;
    pop_data  = '0;
    ready     = 1'b0;
    arst      = 1'b1;
    step();
    step();
    arst = 1'b0;
  endtask

  task automatic set_lane(input int k, input logic [TREE_NUM_BITS-1:0] t, input logic [DW-1:0] d);
    tree_id[k*TREE_NUM_BITS +: TREE_NUM_BITS] = t;
    pop_data[k*DW +: DW] = d;
  endtask

  task automatic test_reset();
    do_reset();
    tests_run++;
    if ({o_valid, o_tree_id, o_data, o_lane, o_lane_full, o_drop_cnt, o_drop_err} !== '0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got valid=%0b tree=%0d data=%h lane=%0d full=%b cnt=%0d err=%0b, need all 0",
               o_valid, o_tree_id, o_data, o_lane, o_lane_full, o_drop_cnt, o_drop_err);
    end
  endtask

  task automatic test_single();
    do_reset();
    ready = 1'b1;
    set_lane(2, 2'd1, 16'h00A5);
    pop_valid = 4'b0100;
    step();
    pop_valid = '0;
    tests_run++;
    if ({o_valid, o_lane, o_tree_id, o_data} !== {1'b1, 2'd2, 2'd1, 16'h00A5}) begin
      tests_failed++;
      $display("FAIL single_egress: got v=%0b lane=%0d tree=%0d data=%h, need v=1 lane=2 tree=1 data=00a5",
               o_valid, o_lane, o_tree_id, o_data);
    end
    step();
    tests_run++;
    if ({o_valid, o_data} !== {1'b0, 16'h0000}) begin
      tests_failed++;
      $display("FAIL single_drained: got v=%0b data=%h, need v=0 data=0000", o_valid, o_data);
    end
  endtask

  task automatic test_fairness();
    do_reset();
    ready = 1'b1;
    for (int k = 0; k < 4; k++) set_lane(k, 2'(k), 16'h0010 + 16'(k));
    pop_valid = 4'b1111;
    step();
    pop_valid = '0;
    for (int k = 0; k < 4; k++) begin
      tests_run++;
      if ({o_valid, o_lane, o_tree_id, o_data} !== {1'b1, 2'(k), 2'(k), 16'h0010 + 16'(k)}) begin
        tests_failed++;
        $display("FAIL fairness_slot%0d: got v=%0b lane=%0d tree=%0d data=%h, need v=1 lane=%0d tree=%0d data=%h",
                 k, o_valid, o_lane, o_tree_id, o_data, k, k, 16'h0010 + 16'(k));
      end
      step();
    end
    tests_run++;
    if (o_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL fairness_empty: got v=%0b, need 0", o_valid);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    ready = 1'b0;
    set_lane(1, 2'd2, 16'h0111);
    pop_valid = 4'b0010;
    step();
    set_lane(1, 2'd3, 16'h0222);
    step();
    pop_valid = '0;
    // Lane 0 sits at the RR pointer; it fills during the stall and must not take the grant.
    for (int c = 0; c < 5; c++) begin
      if (c == 2) begin
        set_lane(0, 2'd0, 16'h0333);
        pop_valid = 4'b0001;
      end else begin
        pop_valid = '0;
      end
      tests_run++;
      if ({o_valid, o_lane, o_tree_id, o_data} !== {1'b1, 2'd1, 2'd2, 16'h0111}) begin
        tests_failed++;
        $display("FAIL bp_hold_cycle%0d: got v=%0b lane=%0d tree=%0d data=%h, need v=1 lane=1 tree=2 data=0111",
                 c, o_valid, o_lane, o_tree_id, o_data);
      end
      step();
    end
    pop_valid = '0;
    ready = 1'b1;
    tests_run++;
    if ({o_lane, o_data} !== {2'd1, 16'h0111}) begin
      tests_failed++;
      $display("FAIL bp_release: got lane=%0d data=%h, need lane=1 data=0111", o_lane, o_data);
    end
    step();
    tests_run++;
    if ({o_valid, o_lane, o_data} !== {1'b1, 2'd0, 16'h0333}) begin
      tests_failed++;
      $display("FAIL bp_rr_next: got v=%0b lane=%0d data=%h, need v=1 lane=0 data=0333", o_valid, o_lane, o_data);
    end
    step();
    tests_run++;
    if ({o_valid, o_lane, o_tree_id, o_data} !== {1'b1, 2'd1, 2'd3, 16'h0222}) begin
      tests_failed++;
      $display("FAIL bp_second: got v=%0b lane=%0d tree=%0d data=%h, need v=1 lane=1 tree=3 data=0222",
               o_valid, o_lane, o_tree_id, o_data);
    end
    step();
    tests_run++;
    if ({o_valid, o_drop_cnt, o_drop_err} !== {1'b0, 8'd0, 1'b0}) begin
      tests_failed++;
      $display("FAIL bp_done: got v=%0b cnt=%0d err=%0b, need v=0 cnt=0 err=0", o_valid, o_drop_cnt, o_drop_err);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      set_lane(0, 2'd1, 16'(i));
      pop_valid = 4'b0001;
      step();
      if (i == 2) begin
        tests_run++;
        if (o_lane_full !== 4'b0000) begin
          tests_failed++;
          $display("FAIL ovf_not_full_at3: got full=%b, need 0000", o_lane_full);
        end
      end
      if (i == 3) begin
        tests_run++;
        if ({o_lane_full, o_drop_cnt} !== {4'b0001, 8'd0}) begin
          tests_failed++;
          $display("FAIL ovf_full_at4: got full=%b cnt=%0d, need full=0001 cnt=0", o_lane_full, o_drop_cnt);
        end
      end
    end
    pop_valid = '0;
    tests_run++;
    if ({o_lane_full, o_drop_cnt, o_drop_err, o_data} !== {4'b0001, 8'd2, 1'b1, 16'h0000}) begin
      tests_failed++;
      $display("FAIL ovf_drops: got full=%b cnt=%0d err=%0b head=%h, need full=0001 cnt=2 err=1 head=0000",
               o_lane_full, o_drop_cnt, o_drop_err, o_data);
    end
    set_lane(0, 2'd1, 16'h0055);
    pop_valid = 4'b0001;
    ready = 1'b1;
    step();
    pop_valid = '0;
    ready = 1'b0;
    tests_run++;
    if ({o_lane_full, o_drop_cnt, o_drop_err, o_data} !== {4'b0001, 8'd2, 1'b1, 16'h0001}) begin
      tests_failed++;
      $display("FAIL ovf_push_pop_full: got full=%b cnt=%0d err=%0b head=%h, need full=0001 cnt=2 err=1 head=0001",
               o_lane_full, o_drop_cnt, o_drop_err, o_data);
    end
  endtask

  task automatic test_saturation_reset();
    do_reset();
    ready = 1'b0;
    for (int k = 0; k < 4; k++) set_lane(k, 2'(k), 16'h1000 + 16'(k));
    pop_valid = 4'b1111;
    for (int c = 0; c < 4; c++) step();
    tests_run++;
    if ({o_lane_full, o_drop_cnt} !== {4'b1111, 8'd0}) begin
      tests_failed++;
      $display("FAIL sat_filled: got full=%b cnt=%0d, need full=1111 cnt=0", o_lane_full, o_drop_cnt);
    end
    for (int c = 0; c < 63; c++) step();
    tests_run++;
    if (o_drop_cnt !== 8'd252) begin
      tests_failed++;
      $display("FAIL sat_252: got cnt=%0d, need 252", o_drop_cnt);
    end
    step();
    tests_run++;
    if (o_drop_cnt !== 8'd255) begin
      tests_failed++;
      $display("FAIL sat_clip: got cnt=%0d, need 255", o_drop_cnt);
    end
    for (int c = 0; c < 11; c++) step();
    tests_run++;
    if ({o_drop_cnt, o_drop_err} !== {8'd255, 1'b1}) begin
      tests_failed++;
      $display("FAIL sat_300: got cnt=%0d err=%0b, need cnt=255 err=1", o_drop_cnt, o_drop_err);
    end
    ready = 1'b1;
    #1;
    arst = 1'b1;
    #2;
    tests_run++;
    if ({o_valid, o_tree_id, o_data, o_lane, o_lane_full, o_drop_cnt, o_drop_err} !== '0) begin
      tests_failed++;
      $display("FAIL sat_async_reset: got valid=%0b tree=%0d data=%h lane=%0d full=%b cnt=%0d err=%0b, need all 0",
               o_valid, o_tree_id, o_data, o_lane, o_lane_full, o_drop_cnt, o_drop_err);
    end
    arst = 1'b0;
    pop_valid = '0;
    step();
    tests_run++;
    if ({o_valid, o_drop_cnt, o_lane_full} !== {1'b0, 8'd0, 4'b0000}) begin
      tests_failed++;
      $display("FAIL sat_after_reset: got v=%0b cnt=%0d full=%b, need v=0 cnt=0 full=0000", o_valid, o_drop_cnt, o_lane_full);
    end
  endtask

  task automatic test_filter();
    do_reset();
    ready = 1'b1;
    set_lane(3, 2'd2, 16'hFFFF);
    pop_valid = 4'b1000;
    step();
    pop_valid = '0;
    tests_run++;
`ifdef POP_EMPTY_FILTER_EN
    if ({o_valid, o_drop_cnt} !== {1'b0, 8'd0}) begin
      tests_failed++;
      $display("FAIL filter_on: got v=%0b cnt=%0d, need v=0 cnt=0", o_valid, o_drop_cnt);
    end
`else
    if ({o_valid, o_lane, o_tree_id, o_data} !== {1'b1, 2'd3, 2'd2, 16'hFFFF}) begin
      tests_failed++;
      $display("FAIL filter_off: got v=%0b lane=%0d tree=%0d data=%h, need v=1 lane=3 tree=2 data=ffff",
               o_valid, o_lane, o_tree_id, o_data);
    end
`endif
    step();
    tests_run++;
    if (o_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL filter_idle: got v=%0b, need 0", o_valid);
    end
  endtask

  initial begin
    arst = 1'b1;
    pop_valid = '0;
    tree_id = '0;
    pop_data = '0;
    ready = 1'b0;
    test_reset();
    test_single();
    test_fairness();
    test_backpressure();
    test_overflow();
    test_saturation_reset();
    test_filter();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
